// File: rtl/approx_adder_share_ctrl.sv
// approx_adder_share_ctrl
//   Shares one WIDTH-bit approximate ripple-carry adder between two requesters
//   with a round-robin grant. The low APPROX_BITS cells are approximate full
//   adders and the remaining upper cells are exact. Each result is captured in
//   a one-entry response buffer tagged with the id of the requester it belongs to.
//
//   Optional feature macro: APPROX_ERR_MON_EN
//     This macro adds an error monitor that compares every accepted approximate sum
//     with the exact a+b. It adds the ports err_clr, err_cnt and err_max.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid[1:0]    per-requester operand valid
//   req_ready[1:0]    per-requester accept (combinational, at most one bit high)
//   req_a0/req_b0     requester 0 operands
//   req_a1/req_b1     requester 1 operands
//   resp_valid        response buffer holds a result
//   resp_ready        consumer accepts the response
//   resp_id           requester that owns resp_sum
//   resp_sum          WIDTH+1 bit approximate sum
//   err_clr           (monitor) synchronous clear of err_cnt/err_max
//   err_cnt           (monitor) saturating count of inexact results
//   err_max           (monitor) largest |approx - exact| seen
module approx_adder_share_ctrl #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH:0]   resp_sum
`ifdef APPROX_ERR_MON_EN
  ,
  input  logic             err_clr,
  output logic [15:0]      err_cnt,
  output logic [WIDTH:0]   err_max
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             buf_free;
  logic             accept;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] sbits_p0;
  logic             carry;
  logic [WIDTH:0]   sum_p0;
  logic [WIDTH:0]   sum_p1;
  logic             id_p1;

  // Stage p0: arbitration, operand select and combinational adder chain
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) grant = ~last_grant;
    else if (req_valid[1])  grant = 1'b1;
  end

  assign buf_free  = (state == EMPTY) || resp_ready;
  // Gating with rst_n keeps both ready bits low during reset even though the
  // state register already reads EMPTY.
  assign req_ready = (rst_n && buf_free) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign a_p0 = grant ? req_a1 : req_a0;
  assign b_p0 = grant ? req_b1 : req_b0;

  always_comb begin
    carry    = 1'b0;
    sbits_p0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < APPROX_BITS) begin
        sbits_p0[i] = b_p0[i] & (a_p0[i] | carry);
        carry       = a_p0[i] | ~b_p0[i];
      end else begin
        sbits_p0[i] = a_p0[i] ^ b_p0[i] ^ carry;
        carry       = (a_p0[i] & b_p0[i]) | (a_p0[i] & carry) | (b_p0[i] & carry);
      end
    end
    sum_p0 = {carry, sbits_p0};
  end

  // Stage p1: response buffer and its EMPTY/FULL state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      id_p1      <= 1'b0;
      sum_p1     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= FULL;
        end
        FULL: begin
          if (resp_ready && !accept) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
      if (accept) begin
        sum_p1     <= sum_p0;
        id_p1      <= grant;
        last_grant <= grant;
      end
    end
  end

  assign resp_valid = (state == FULL);
  assign resp_id    = id_p1;
  assign resp_sum   = sum_p1;

`ifdef APPROX_ERR_MON_EN
  logic [WIDTH:0] exact_p0;
  logic [WIDTH:0] diff_p0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign exact_p0 = {1'b0, a_p0} + {1'b0, b_p0};
  assign diff_p0  = (sum_p0 >= exact_p0) ? (sum_p0 - exact_p0) : (exact_p0 - sum_p0);

  // Stage p1: error statistics, clear has priority over a same-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (accept) begin
      if (sum_p0 != exact_p0) err_cnt <= sat_inc(err_cnt);
      if (diff_p0 > err_max)  err_max <= diff_p0;
    end
  end
`endif

endmodule

// File: tb/tb_approx_adder_share_ctrl.sv
module tb_approx_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] a0, b0, a1, b1;
  logic        resp_valid, resp_ready, resp_id;
  logic [16:0] resp_sum;

  logic [1:0]  ex_valid;
  logic [1:0]  ex_ready;
  logic [15:0] ex_a0, ex_b0, ex_a1, ex_b1;
  logic        ex_resp_valid, ex_resp_ready, ex_resp_id;
  logic [16:0] ex_resp_sum;

`ifdef APPROX_ERR_MON_EN
  logic        err_clr;
  logic [15:0] err_cnt, ex_err_cnt;
  logic [16:0] err_max, ex_err_max;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [16:0] sum;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[6];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp;
  } exv_t;
  exv_t extbl[3];

  always #5 clk = ~clk;

  approx_adder_share_ctrl #(.WIDTH(16), .APPROX_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum)
`ifdef APPROX_ERR_MON_EN
    , .err_clr(err_clr), .err_cnt(err_cnt), .err_max(err_max)
`endif
  );

  approx_adder_share_ctrl #(.WIDTH(16), .APPROX_BITS(0)) dut_ex (
    .clk(clk), .rst_n(rst_n), .req_valid(ex_valid), .req_ready(ex_ready),
    .req_a0(ex_a0), .req_b0(ex_b0), .req_a1(ex_a1), .req_b1(ex_b1),
    .resp_valid(ex_resp_valid), .resp_ready(ex_resp_ready), .resp_id(ex_resp_id),
    .resp_sum(ex_resp_sum)
`ifdef APPROX_ERR_MON_EN
    , .err_clr(err_clr), .err_cnt(ex_err_cnt), .err_max(ex_err_max)
`endif
  );

  // Reference for the mixed approximate/exact ripple chain.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input int nab);
    logic        c;
    logic        cn;
    logic [15:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < nab) begin
        s[i] = b[i] & (a[i] | c);
        cn   = a[i] | ~b[i];
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        cn   = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      c = cn;
    end
    return {c, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: push on every accepted request, pop on every drained response.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_resp", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_resp_id", {31'd0, resp_id}, {31'd0, e.id});
          chk("sb_resp_sum", {15'd0, resp_sum}, {15'd0, e.sum});
        end
      end
      chk("ready_onehot0", {31'd0, ($countones(req_ready) > 1)}, 32'd0);
      if (req_valid[0] && req_ready[0]) sb.push_back('{1'b0, model(a0, b0, 10)});
      if (req_valid[1] && req_ready[1]) sb.push_back('{1'b1, model(a1, b1, 10)});
    end
  end

  task automatic xfer(input logic id, input logic [15:0] a, input logic [15:0] b, output bit ok);
    @(posedge clk); #1;
    if (id) begin a1 = a; b1 = b; req_valid = 2'b10; end
    else    begin a0 = a; b0 = b; req_valid = 2'b01; end
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [1:0]  acc;
    logic        id, prev;
    logic        hold_id;
    logic [16:0] hold_sum;

    tbl[0] = '{1'b0, 16'h0000, 16'h0000, 17'h00400};
    tbl[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 17'h1FFFF};
    tbl[2] = '{1'b0, 16'hFFFF, 16'h0000, 17'h10000};
    tbl[3] = '{1'b1, 16'h0000, 16'hFFFF, 17'h0FC00};
    tbl[4] = '{1'b0, 16'h1234, 16'h0000, 17'h01400};
    tbl[5] = '{1'b1, 16'h03FF, 16'h0001, 17'h00401};
    extbl[0] = '{16'h0001, 16'h0000, 17'h00001};
    extbl[1] = '{16'h1234, 16'h4321, 17'h05555};
    extbl[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};

    rst_n = 1'b0;
    req_valid = 2'b11;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    resp_ready = 1'b1;
    ex_valid = 2'b00; ex_a0 = '0; ex_b0 = '0; ex_a1 = '0; ex_b1 = '0;
    ex_resp_ready = 1'b1;
`ifdef APPROX_ERR_MON_EN
    err_clr = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_resp_sum", {15'd0, resp_sum}, 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Table of single-requester transfers
    for (int i = 0; i < 6; i++) begin
`ifdef APPROX_ERR_MON_EN
      if (i == 1) begin
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
      end
`endif
      xfer(tbl[i].id, tbl[i].a, tbl[i].b, ok);
      chk($sformatf("tbl%0d_accept", i), {31'd0, ok}, 32'd1);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("tbl%0d_id", i), {31'd0, resp_id}, {31'd0, tbl[i].id});
      chk($sformatf("tbl%0d_sum", i), {15'd0, resp_sum}, {15'd0, tbl[i].exp});
`ifdef APPROX_ERR_MON_EN
      if (i == 1) begin
        chk("err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("err_max", {15'd0, err_max}, 32'd1);
      end
`endif
    end

    // Both valid every cycle: strict alternation, one accept per cycle
    @(posedge clk); #1;
    a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    req_valid = 2'b11;
    prev = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      chk("t3_one_accept", $countones(acc), 32'd1);
      id = acc[1];
      chk($sformatf("t3_grant%0d", k), {31'd0, id}, {31'd0, ~prev});
      prev = id;
      @(posedge clk); #1;
      if (id) begin a1 = 16'($urandom); b1 = 16'($urandom); end
      else    begin a0 = 16'($urandom); b0 = 16'($urandom); end
    end

    // Back-pressure with both requesters waiting, then drain + refill
    resp_ready = 1'b0;
    @(negedge clk);
    hold_id  = resp_id;
    hold_sum = resp_sum;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t4_ready_low", {30'd0, req_ready}, 32'd0);
      chk("t4_valid_hold", {31'd0, resp_valid}, 32'd1);
      chk("t4_id_hold", {31'd0, resp_id}, {31'd0, hold_id});
      chk("t4_sum_hold", {15'd0, resp_sum}, {15'd0, hold_sum});
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    acc = req_valid & req_ready;
    chk("t4_refill_count", $countones(acc), 32'd1);
    chk("t4_refill_id", {31'd0, acc[1]}, {31'd0, ~hold_id});

    // Asynchronous reset while FULL and stalled
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("t5_full", {31'd0, resp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid_zero", {31'd0, resp_valid}, 32'd0);
    chk("t5_id_zero", {31'd0, resp_id}, 32'd0);
    chk("t5_sum_zero", {15'd0, resp_sum}, 32'd0);
    chk("t5_ready_zero", {30'd0, req_ready}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t5_first_tie", {30'd0, req_valid & req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("t5_resp_id", {31'd0, resp_id}, 32'd0);

    // Exact adder instance (APPROX_BITS=0)
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ex_a0 = extbl[i].a; ex_b0 = extbl[i].b; ex_valid = 2'b01;
      @(negedge clk);
      chk($sformatf("ex%0d_ready", i), {30'd0, ex_ready}, 32'd1);
      @(posedge clk); #1;
      ex_valid = 2'b00;
      @(negedge clk);
      chk($sformatf("ex%0d_valid", i), {31'd0, ex_resp_valid}, 32'd1);
      chk($sformatf("ex%0d_id", i), {31'd0, ex_resp_id}, 32'd0);
      chk($sformatf("ex%0d_sum", i), {15'd0, ex_resp_sum}, {15'd0, extbl[i].exp});
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("final_idle", {31'd0, resp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
